// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if
// Purpose: frame-buffer program port between sprite_blitter (master) and the
//          SRAM controller (slave).
// Signals:
//   program_x     [9:0]  frame-buffer x of the current write
//   program_y     [9:0]  frame-buffer y of the current write
//   program_data  [15:0] RGB565 pixel of the current write
//   program_write        write request, held until program_ready
//   program_ready        slave accepts the write on this clk
interface sprite_blitter_if;
    logic [9:0]  program_x;
    logic [9:0]  program_y;
    logic [15:0] program_data;
    logic        program_write;
    logic        program_ready;

    modport master (
        output program_x,
        output program_y,
        output program_data,
        output program_write,
        input  program_ready
    );

    modport slave (
        input  program_x,
        input  program_y,
        input  program_data,
        input  program_write,
        output program_ready
    );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter
// Purpose: on each rising frame tick, copies one SPRITE_W x SPRITE_H sprite from
//          an external ROM into the frame buffer at (sprite_x, sprite_y), one
//          write per opaque, on-screen pixel. Transparent pixels are skipped and
//          pixels beyond SCREEN_W/SCREEN_H are clipped.
// Ports:
//   clk          system clock, posedge
//   rst          asynchronous active-high reset
//   i_frame_clk  frame tick; a rising edge starts a blit when idle
//   i_sprite_x   sprite top-left x, sampled at start
//   i_sprite_y   sprite top-left y, sampled at start
//   i_mirror_x   (BLIT_MIRROR_EN only) horizontal flip, sampled at start
//   o_rom_addr   sprite ROM address, row*SPRITE_W + col
//   i_rom_data   ROM pixel, valid one clk after o_rom_addr
//   o_busy       high while a blit is in progress
//   o_done       one-clk pulse when the blit completes
//   prog         program port (master side)
// Configuration: define BLIT_MIRROR_EN to add i_mirror_x and the flipped
//                ROM read order; sequencing and timing are unchanged.
//
// state   | meaning
// IDLE    | waiting for a frame tick edge
// READ    | rom_addr presented for the current pixel
// WAIT    | ROM data valid; decide write or skip
// WRITE   | program_write held until program_ready
// NEXT    | advance col/row, or finish after the last pixel
// DONE    | one-clk completion pulse
module sprite_blitter #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter logic [15:0] TRANSPARENT = 16'b1111100000011111,
    parameter int          ROM_AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_frame_clk,
    input  logic [9:0]        i_sprite_x,
    input  logic [9:0]        i_sprite_y,
`ifdef BLIT_MIRROR_EN
    input  logic              i_mirror_x,
`endif
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_busy,
    output logic              o_done,
    sprite_blitter_if.master  prog
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(SPRITE_W - 1);
    localparam logic [6:0] LAST_ROW = 7'(SPRITE_H - 1);

    state_t      r_state;
    logic        r_fclk;
    logic        r_fclk_q;
    logic [9:0]  r_x0;
    logic [9:0]  r_y0;
    logic [6:0]  r_row;
    logic [6:0]  r_col;
    logic        w_start;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic        w_visible;
    logic        w_mir_start;
    logic        w_mir;

`ifdef BLIT_MIRROR_EN
    logic        r_mirror;
    assign w_mir_start = i_mirror_x;
    assign w_mir       = r_mirror;
`else
    assign w_mir_start = 1'b0;
    assign w_mir       = 1'b0;
`endif

    // frame_clk is synchronised first, then edge-detected
    assign w_start = r_fclk & ~r_fclk_q;

    // 11-bit sums so an origin near the right/bottom edge never wraps back on screen
    assign w_px      = {1'b0, r_x0} + {4'b0, r_col};
    assign w_py      = {1'b0, r_y0} + {4'b0, r_row};
    assign w_visible = (i_rom_data != TRANSPARENT) &&
                       (w_px < 11'(SCREEN_W)) && (w_py < 11'(SCREEN_H));

    function automatic logic [ROM_AW-1:0] addr_of(input logic [6:0] row,
                                                  input logic [6:0] col,
                                                  input logic       mir);
        logic [6:0] c;
        c = mir ? (LAST_COL - col) : col;
        return ROM_AW'(32'(row) * 32'(SPRITE_W) + 32'(c));
    endfunction

    // The next pixel's address is registered on entry to READ so that
    // rom_addr is stable for the whole READ cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_fclk             <= 1'b0;
            r_fclk_q           <= 1'b0;
            r_x0               <= '0;
            r_y0               <= '0;
            r_row              <= '0;
            r_col              <= '0;
            o_rom_addr         <= '0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            prog.program_x     <= '0;
            prog.program_y     <= '0;
            prog.program_data  <= '0;
            prog.program_write <= 1'b0;
`ifdef BLIT_MIRROR_EN
            r_mirror           <= 1'b0;
`endif
        end else begin
            r_fclk   <= i_frame_clk;
            r_fclk_q <= r_fclk;
            o_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_x0       <= i_sprite_x;
                        r_y0       <= i_sprite_y;
                        r_row      <= '0;
                        r_col      <= '0;
                        o_rom_addr <= addr_of(7'd0, 7'd0, w_mir_start);
                        o_busy     <= 1'b1;
`ifdef BLIT_MIRROR_EN
                        r_mirror   <= i_mirror_x;
`endif
                        r_state    <= S_READ;
                    end
                end
                S_READ: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_visible) begin
                        prog.program_x     <= w_px[9:0];
                        prog.program_y     <= w_py[9:0];
                        prog.program_data  <= i_rom_data;
                        prog.program_write <= 1'b1;
                        r_state            <= S_WRITE;
                    end else begin
                        r_state <= S_NEXT;
                    end
                end
                S_WRITE: begin
                    if (prog.program_ready) begin
                        prog.program_write <= 1'b0;
                        r_state            <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        if (r_row == LAST_ROW) begin
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row      <= r_row + 7'd1;
                            o_rom_addr <= addr_of(r_row + 7'd1, 7'd0, w_mir);
                            r_state    <= S_READ;
                        end
                    end else begin
                        r_col      <= r_col + 7'd1;
                        o_rom_addr <= addr_of(r_row, r_col + 7'd1, w_mir);
                        r_state    <= S_READ;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
